// File: rtl/alu_pkg.sv
// alu_pkg: operation codes shared with ALU_Control_unit, the execution FSM
// state type and the default datapath width for alu_exec_unit.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: bit-serial shifter for SLL/SRL/SRA, one bit position per
// cycle. Loaded on start_i; done_o strobes in the cycle whose clock edge
// performs the final shift, and result_o carries that final value.
// Only built when ALU_EXEC_SHIFT_EN is defined.
`ifdef ALU_EXEC_SHIFT_EN
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [4:0]       shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);

    logic [4:0]       count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] step;

    // One-bit shift of the current value in the captured direction
    always_comb begin
        step = shreg_q;
        case (op_q)
            OP_SLL:  step = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, shreg_q[WIDTH-1:1]};
            default: step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
        endcase
    end

    // Load on start, otherwise shift and count down while work remains
    always_comb begin
        count_d = count_q;
        shreg_d = shreg_q;
        op_d    = op_q;
        if (start_i) begin
            count_d = shamt_i;
            shreg_d = data_i;
            op_d    = op_i;
        end else if (count_q != 5'd0) begin
            count_d = count_q - 5'd1;
            shreg_d = step;
        end
    end

    // Shifter state registers; reset discards any shift in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 5'd0;
            shreg_q <= '0;
            op_q    <= OP_SLL;
        end else begin
            count_q <= count_d;
            shreg_q <= shreg_d;
            op_q    <= op_d;
        end
    end

    assign result_o = step;
    assign done_o   = (count_q == 5'd1);

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready wrapped ALU. Single-cycle ops (AND/OR/ADD/SUB/SLT)
// and unsupported codes complete with latency 1; the result is held in DONE
// until the consumer takes it. With ALU_EXEC_SHIFT_EN defined, SLL/SRL/SRA are
// executed bit-serially in EXEC by alu_serial_shifter; without it those codes
// are reported as illegal and EXEC is never entered.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    illegal_q, illegal_d;

    logic                    accept;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ill;
    logic                    is_shift;
    logic [4:0]              shamt;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        sh_res;
    logic                    sh_done;

    // Held low during reset so nothing is accepted while rst_n is asserted
    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    assign shamt = op_b[4:0];
    assign a_s   = op_a;
    assign b_s   = op_b;

    // Single-cycle operation decode; shifts pass op_a through for shamt 0
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (alu_ctrl)
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_ADD: alu_res = op_a + op_b;
            OP_SUB: alu_res = op_a - op_b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
`ifdef ALU_EXEC_SHIFT_EN
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                alu_res  = op_a;
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    logic sh_start;

    assign sh_start = accept && is_shift && (shamt != 5'd0);

    alu_serial_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (sh_start),
        .op_i     (alu_ctrl),
        .data_i   (op_a),
        .shamt_i  (shamt),
        .result_o (sh_res),
        .done_o   (sh_done)
    );
`else
    assign sh_res  = '0;
    assign sh_done = 1'b0;
`endif

    // Next state and output capture; an acceptance overrides a DONE retire
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            EXEC: begin
                if (sh_done) begin
                    state_d   = DONE;
                    result_d  = sh_res;
                    zero_d    = (sh_res == '0);
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (is_shift && (shamt != 5'd0)) begin
                state_d = EXEC;
            end else begin
                state_d   = DONE;
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                illegal_d = alu_ill;
            end
        end
    end

    // State and result registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: table of operations with expected results fed
// back-to-back through a scoreboard queue, plus hand-written sequences for
// stall, reset and (with ALU_EXEC_SHIFT_EN) serial-shift corner cases.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        il;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        il;
        int          tag;
    } exp_t;

    vec_t tv[20];
    int   n_vec;
    exp_t exp_q[$];
    exp_t mon_e;
    int   total;
    int   bad;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic z, input logic il);
        tv[n_vec].c  = c;
        tv[n_vec].a  = a;
        tv[n_vec].b  = b;
        tv[n_vec].r  = r;
        tv[n_vec].z  = z;
        tv[n_vec].il = il;
        n_vec++;
    endtask

    // Drive a request, wait (bounded) for acceptance, record expectation
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z, input logic il,
                        input bit push, input int tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout tag%0d: in_ready got %0b required 1", tag, in_ready);
        end else if (push) begin
            e.res = r;
            e.z   = z;
            e.il  = il;
            e.tag = tag;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare every retired result against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got result %h with no pending request", result);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("result_tag%0d", mon_e.tag), result, mon_e.res);
                chk($sformatf("zero_tag%0d", mon_e.tag), {31'b0, zero}, {31'b0, mon_e.z});
                chk($sformatf("illegal_tag%0d", mon_e.tag), {31'b0, illegal}, {31'b0, mon_e.il});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        n_vec     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'b0;
        op_a      = 32'b0;
        op_b      = 32'b0;

        add_vec(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
        add_vec(OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        add_vec(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
        add_vec(OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0);
        add_vec(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        add_vec(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        add_vec(OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1);
        add_vec(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
`ifndef ALU_EXEC_SHIFT_EN
        add_vec(OP_SLL, 32'h0000_0001, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1);
        add_vec(OP_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1);
        add_vec(OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1);
`endif

        // Outputs while reset is asserted
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Table vectors back-to-back with the consumer always ready
        for (int i = 0; i < n_vec; i++) begin
            send(tv[i].c, tv[i].a, tv[i].b, tv[i].r, tv[i].z, tv[i].il, 1'b1, i);
            chk($sformatf("latency1_vec%0d", i), {31'b0, out_valid}, 32'd1);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("idle_after_table", {31'b0, out_valid}, 32'd0);

        // SUB 5-5 then SLT -1,1 on consecutive cycles
        send(OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1, 100);
        chk("b2b_first_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_first_result", result, 32'd0);
        chk("b2b_first_zero", {31'b0, zero}, 32'd1);
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 101);
        chk("b2b_second_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_second_result", result, 32'd1);
        repeat (2) @(negedge clk);

        // Consumer stalls three cycles, result must hold
        out_ready = 1'b0;
        send(OP_AND, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h0E0D_0E0F, 1'b0, 1'b0, 1'b1, 102);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_result", k), result, 32'h0E0D_0E0F);
            chk($sformatf("stall%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_retire_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("stall_after_retire_valid", {31'b0, out_valid}, 32'd0);

        // Reset while a result sits in DONE
        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 103);
        chk("pre_rst_result", result, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("after_rst_out_valid", {31'b0, out_valid}, 32'd0);
        end

`ifdef ALU_EXEC_SHIFT_EN
        // SRA by 4: five cycles from acceptance, other requests ignored in EXEC
        send(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1, 200);
        alu_ctrl = OP_AND;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("sra_wait%0d_valid", k), {31'b0, out_valid}, 32'd0);
            chk($sformatf("sra_wait%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
            if (k == 4) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("sra_done_valid", {31'b0, out_valid}, 32'd1);
        chk("sra_done_result", result, 32'hF800_0000);
        send(OP_SLL, 32'h0000_0001, 32'd0, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 201);
        chk("sll0_latency1", {31'b0, out_valid}, 32'd1);
        send(OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 202);
        send(OP_SLL, 32'h0000_0003, 32'd3, 32'h0000_0018, 1'b0, 1'b0, 1'b1, 203);
        repeat (40) @(negedge clk);

        // Reset pulse two cycles into a shift discards it
        send(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 204);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("sra_rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sra_rst_quiet%0d", k), {31'b0, out_valid}, 32'd0);
        end
        chk("sra_rst_idle", {31'b0, in_ready}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request carries valid alu_ctrl/op_a/op_b.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 alu_ctrl  input  4  operation code as driven by ALU_Control_unit.
REQ-007 op_a  input  WIDTH  first operand.
REQ-008 op_b  input  WIDTH  second operand; shift amount in op_b[4:0] for shift ops.
REQ-009 out_valid  output  1  result/zero/illegal are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  high when result equals 0.
REQ-013 illegal  output  1  high when the accepted alu_ctrl is not a supported code.

Function
REQ-014 Codes SHALL be: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, SLT 4'b0111.
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT SHALL be a signed compare returning 1 or 0 zero-extended.
REQ-016 Acceptance SHALL occur on a cycle where in_valid && in_ready; alu_ctrl and operands are captured then.
REQ-017 FSM states SHALL be IDLE, EXEC, DONE; the unit resets to IDLE.
REQ-018 IDLE: on acceptance of a single-cycle op or an illegal code -> DONE; on acceptance of a shift op -> EXEC (see REQ-028).
REQ-019 Single-cycle ops SHALL assert out_valid in the cycle after acceptance (latency 1).
REQ-020 Unsupported codes SHALL complete with latency 1, result 0, zero 1, illegal 1.
REQ-021 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-022 DONE with out_ready high: output retires; a simultaneous new acceptance enters DONE/EXEC directly (back-to-back, one result per cycle for single-cycle ops).
REQ-023 DONE with out_ready low: result, zero, illegal SHALL hold stable and out_valid stay high.
REQ-024 DONE with out_ready high and no acceptance -> IDLE with out_valid low next cycle.
REQ-025 in_valid while in EXEC SHALL be ignored (in_ready low); requesters hold their inputs.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, zero 0, illegal 0, in_ready 0 while asserted.
REQ-027 Reset mid-EXEC or mid-DONE SHALL discard the in-flight operation; in_ready rises the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro ALU_EXEC_SHIFT_EN defined: codes SLL 4'b0011, SRL 4'b0100, SRA 4'b0101 supported; EXEC shifts one bit per cycle for op_b[4:0] cycles, then DONE; shift amount 0 goes straight to DONE with result op_a; out_valid at acceptance+1+shamt.
REQ-029 Macro undefined: codes 0011/0100/0101 are unsupported per REQ-020; EXEC is unreachable.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 4-bit operation code constants (shared with ALU_Control_unit), the FSM state enum and WIDTH default.
REQ-031 One sub-module, alu_serial_shifter (count register, shift register, done strobe), SHALL exist only under ALU_EXEC_SHIFT_EN.

Verification
REQ-032 ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid 1 cycle later, result 0x80000000, zero 0, illegal 0.
REQ-033 SUB 5-5 followed back-to-back by SLT 0xFFFFFFFF,1 -> results 0 (zero 1) then 1, on consecutive cycles.
REQ-034 AND with out_ready low for 3 cycles -> result held, in_ready low, retire on the 4th cycle.
REQ-035 alu_ctrl 4'b1111 -> result 0, zero 1, illegal 1, latency 1.
REQ-036 With ALU_EXEC_SHIFT_EN: SRA 0x80000000 by 4 -> out_valid 5 cycles after acceptance, result 0xF8000000; rst_n pulse at cycle 2 -> out_valid never rises, state IDLE.
